wb_stage: RTL

Registered, handshaked write-back stage for the riscvBoy core, sitting between the memory stage and the register file write port.
- Selects among four result sources: ALU, load data, CSR and PC+4.
- Aligns and sign- or zero-extends load data from a parametrised-width data bus.
- Waits for late load responses and discards responses that belong to flushed loads.
- Exposes the pending load destination register so the hazard unit can stall.

---
 rtl/core_pkg.sv | 20 ++
 rtl/wb_load_fmt.sv | 59 +++++
 rtl/wb_stage.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared encodings for the write-back stage: result sources, load sizes and FSM states.
package core_pkg;

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_MEM = 2'd1;
    localparam logic [1:0] SRC_CSR = 2'd2;
    localparam logic [1:0] SRC_PC4 = 2'd3;

    localparam logic [1:0] LD_B = 2'd0;
    localparam logic [1:0] LD_H = 2'd1;
    localparam logic [1:0] LD_W = 2'd2;
    localparam logic [1:0] LD_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_WAIT = 2'd1,
        DRAIN   = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_load_fmt.sv
// Load data formatter: selects the addressed lane, shifts it to bit 0 and
// sign- or zero-extends it to XLEN.
module wb_load_fmt
    import core_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned LSB_W = 2
) (
    input  logic [XLEN-1:0]  rdata,
    input  logic [1:0]       size,
    input  logic             ld_unsigned,
    input  logic [LSB_W-1:0] lsb,
    output logic [XLEN-1:0]  result
);

    localparam logic [XLEN-1:0] MASK_B = XLEN'(8'hFF);
    localparam logic [XLEN-1:0] MASK_H = XLEN'(16'hFFFF);
    localparam logic [XLEN-1:0] MASK_W = XLEN'(32'hFFFF_FFFF);

    logic [LSB_W-1:0] byte_off;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  mask;
    logic             sign;

    // Clearing low offset bits keeps lanes naturally aligned; with XLEN=32 the
    // word mask also forces the word lane (and the double case) to zero.
    always_comb begin
        byte_off = '0;
        mask     = '1;
        sign     = 1'b0;
        case (size)
            LD_B: byte_off = lsb;
            LD_H: byte_off = lsb & ~LSB_W'(1);
            LD_W: byte_off = lsb & ~LSB_W'(3);
            default: byte_off = '0;
        endcase
        shifted = rdata >> {byte_off, 3'b000};
        case (size)
            LD_B: begin
                mask = MASK_B;
                sign = shifted[7];
            end
            LD_H: begin
                mask = MASK_H;
                sign = shifted[15];
            end
            LD_W: begin
                mask = MASK_W;
                sign = shifted[31];
            end
            default: begin
                mask = '1;
                sign = 1'b0;
            end
        endcase
        result = (sign & ~ld_unsigned) ? (shifted | ~mask) : (shifted & mask);
    end

endmodule

// File: rtl/wb_stage.sv
// Registered, handshaked write-back stage: result select, load formatting,
// late-response wait and flushed-load drain.
module wb_stage
    import core_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5,
    localparam int unsigned LSB_W = $clog2(XLEN / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_flush,
    input  logic              i_rd_wen,
    input  logic [RA_W-1:0]   i_rd_addr,
    input  logic [1:0]        i_src_sel,
    input  logic [XLEN-1:0]   i_alu_result,
    input  logic [XLEN-1:0]   i_csr_rdata,
    input  logic [XLEN-1:0]   i_pc,
    input  logic [1:0]        i_ld_size,
    input  logic              i_ld_unsigned,
    input  logic [LSB_W-1:0]  i_addr_lsb,
    input  logic              i_mem_rvalid,
    input  logic [XLEN-1:0]   i_mem_rdata,
    output logic              o_rd_wen,
    output logic [RA_W-1:0]   o_rd_addr,
    output logic [XLEN-1:0]   o_rd_wdata,
    output logic              o_pend_valid,
    output logic [RA_W-1:0]   o_pend_addr
);

    wb_state_e        state_q, state_d;
    logic             wen_q, wen_d;
    logic [RA_W-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic             pwen_q, pwen_d;
    logic [RA_W-1:0]  paddr_q, paddr_d;
    logic [1:0]       psize_q, psize_d;
    logic             puns_q, puns_d;
    logic [LSB_W-1:0] plsb_q, plsb_d;

    logic             accept;
    logic [XLEN-1:0]  fmt_data;
    logic [XLEN-1:0]  sel_data;
    logic [1:0]       fmt_size;
    logic             fmt_uns;
    logic [LSB_W-1:0] fmt_lsb;

    // One formatter serves both the zero-latency path and the waiting load.
    assign fmt_size = (state_q == IDLE) ? i_ld_size     : psize_q;
    assign fmt_uns  = (state_q == IDLE) ? i_ld_unsigned : puns_q;
    assign fmt_lsb  = (state_q == IDLE) ? i_addr_lsb    : plsb_q;

    wb_load_fmt #(
        .XLEN  (XLEN),
        .LSB_W (LSB_W)
    ) u_fmt (
        .rdata       (i_mem_rdata),
        .size        (fmt_size),
        .ld_unsigned (fmt_uns),
        .lsb         (fmt_lsb),
        .result      (fmt_data)
    );

    assign o_ready      = (state_q == IDLE);
    assign accept       = i_valid & o_ready & ~i_flush;
    assign o_rd_wen     = wen_q;
    assign o_rd_addr    = addr_q;
    assign o_rd_wdata   = wdata_q;
    assign o_pend_valid = (state_q == LD_WAIT) & pwen_q & (paddr_q != '0);
    assign o_pend_addr  = paddr_q;

    always_comb begin
        sel_data = i_alu_result;
        case (i_src_sel)
            SRC_ALU: sel_data = i_alu_result;
            SRC_MEM: sel_data = fmt_data;
            SRC_CSR: sel_data = i_csr_rdata;
            default: sel_data = i_pc + XLEN'(4);
        endcase
    end

    always_comb begin
        state_d = state_q;
        wen_d   = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pwen_d  = pwen_q;
        paddr_d = paddr_q;
        psize_d = psize_q;
        puns_d  = puns_q;
        plsb_d  = plsb_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (i_src_sel != SRC_MEM || i_mem_rvalid) begin
                        wen_d   = i_rd_wen & (i_rd_addr != '0);
                        addr_d  = i_rd_addr;
                        wdata_d = sel_data;
                    end else begin
                        pwen_d  = i_rd_wen;
                        paddr_d = i_rd_addr;
                        psize_d = i_ld_size;
                        puns_d  = i_ld_unsigned;
                        plsb_d  = i_addr_lsb;
                        state_d = LD_WAIT;
                    end
                end
            end
            LD_WAIT: begin
                // A flush coinciding with the response consumes it, so no drain is needed.
                if (i_flush) begin
                    state_d = i_mem_rvalid ? IDLE : DRAIN;
                end else if (i_mem_rvalid) begin
                    wen_d   = pwen_q & (paddr_q != '0);
                    addr_d  = paddr_q;
                    wdata_d = fmt_data;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (i_mem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            pwen_q  <= 1'b0;
            paddr_q <= '0;
            psize_q <= '0;
            puns_q  <= 1'b0;
            plsb_q  <= '0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pwen_q  <= pwen_d;
            paddr_q <= paddr_d;
            psize_q <= psize_d;
            puns_q  <= puns_d;
            plsb_q  <= plsb_d;
        end
    end

endmodule
